// File: rtl/pc_bsc_pkg.sv
// Shared types, constants and helpers for the BSC error-pattern generator.
// Saturating counter helper assumes counter widths of at most SAT_W bits.
package pc_bsc_pkg;

    localparam int PRNG_W = 32;
    localparam int SH_A   = 13;
    localparam int SH_B   = 17;
    localparam int SH_C   = 5;
    localparam int SAT_W  = 64;

    localparam logic [PRNG_W-1:0] ZERO_SEED_SUB = 32'h2545F491;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2
    } state_e;

    function automatic logic [PRNG_W-1:0] xorshift32(input logic [PRNG_W-1:0] x);
        logic [PRNG_W-1:0] t;
        t = x ^ (x << SH_A);
        t = t ^ (t >> SH_B);
        t = t ^ (t << SH_C);
        return t;
    endfunction

    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input logic [SAT_W-1:0] max);
        logic [SAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max}) begin
            return max;
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/pc_xorshift32_lane.sv
// One lane: 32-bit xorshift state plus threshold compare on the next state.
module pc_xorshift32_lane
    import pc_bsc_pkg::*;
#(
    parameter int                PROB_W   = 16,
    parameter logic [PRNG_W-1:0] LANE_IDX = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [31:0]       seed,
    input  logic              step,
    input  logic [PROB_W-1:0] cp,
    output logic              lane_bit
);

    logic [PRNG_W-1:0] x_q;
    logic [PRNG_W-1:0] x_d;
    logic [PRNG_W-1:0] x_next;

    // The bit belongs to the state the lane is about to move to, so the top
    // can register it on the same edge that advances the PRNG.
    always_comb begin
        x_next   = xorshift32(x_q);
        lane_bit = (x_next[PRNG_W-1 -: PROB_W] < cp);
        x_d      = x_q;
        if (load) begin
            x_d = (seed == '0) ? (ZERO_SEED_SUB ^ LANE_IDX) : seed;
        end else if (step) begin
            x_d = x_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= '0;
        end else begin
            x_q <= x_d;
        end
    end

endmodule

// File: rtl/pc_bsc_noise_gen.sv
// Binary-symmetric-channel error-pattern generator with valid/ready output.
// Statistics counters are built only when PC_BSC_STATS_EN is defined.
module pc_bsc_noise_gen
    import pc_bsc_pkg::*;
#(
    parameter int LANES  = 256,
    parameter int PROB_W = 16,
    parameter int CNT_W  = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LANES*32-1:0]        seed,
    input  logic [PROB_W-1:0]          cross_prob,
    input  logic                       load,
    input  logic                       enable,
    input  logic                       err_ready,
    output logic                       err_valid,
    output logic [LANES-1:0]           err_pat,
    output logic [$clog2(LANES+1)-1:0] err_weight,
    output logic                       busy,
    output logic [CNT_W-1:0]           beat_cnt,
    output logic [CNT_W-1:0]           ones_cnt
);

    localparam int WGT_W = $clog2(LANES+1);

    state_e            state_q, state_d;
    logic [PROB_W-1:0] cp_q, cp_d;
    logic [LANES-1:0]  err_pat_q, err_pat_d;
    logic [WGT_W-1:0]  err_weight_q, err_weight_d;
    logic              err_valid_q, err_valid_d;
    logic [LANES-1:0]  lane_bits;
    logic              gen_step;

    function automatic logic [WGT_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [WGT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            cnt = cnt + WGT_W'(v[i]);
        end
        return cnt;
    endfunction

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pc_xorshift32_lane #(
            .PROB_W  (PROB_W),
            .LANE_IDX(PRNG_W'(i))
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .load    (load),
            .seed    (seed[32*i +: 32]),
            .step    (gen_step),
            .cp      (cp_q),
            .lane_bit(lane_bits[i])
        );
    end

    // Load wins over everything and kills any pending beat without an accept.
    always_comb begin
        state_d      = state_q;
        cp_d         = cp_q;
        err_pat_d    = err_pat_q;
        err_weight_d = err_weight_q;
        err_valid_d  = err_valid_q;
        gen_step     = 1'b0;
        if (load) begin
            state_d     = SEED;
            cp_d        = cross_prob;
            err_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                SEED:    state_d = RUN;
                RUN:     gen_step = enable && (!err_valid_q || err_ready);
                default: state_d = IDLE;
            endcase
            if (gen_step) begin
                err_pat_d    = lane_bits;
                err_weight_d = popcount(lane_bits);
                err_valid_d  = 1'b1;
            end else if (err_valid_q && err_ready) begin
                err_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cp_q         <= '0;
            err_pat_q    <= '0;
            err_weight_q <= '0;
            err_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cp_q         <= cp_d;
            err_pat_q    <= err_pat_d;
            err_weight_q <= err_weight_d;
            err_valid_q  <= err_valid_d;
        end
    end

    assign err_valid  = err_valid_q;
    assign err_pat    = err_pat_q;
    assign err_weight = err_weight_q;
    assign busy       = (state_q != IDLE);

`ifdef PC_BSC_STATS_EN
    localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
    logic [SAT_W-1:0] beat_sum, ones_sum;
    logic             accept;

    always_comb begin
        accept     = err_valid_q && err_ready && !load;
        beat_sum   = sat_add(SAT_W'(beat_cnt_q), SAT_W'(1), CNT_MAX);
        ones_sum   = sat_add(SAT_W'(ones_cnt_q), SAT_W'(err_weight_q), CNT_MAX);
        beat_cnt_d = beat_cnt_q;
        ones_cnt_d = ones_cnt_q;
        if (load) begin
            beat_cnt_d = '0;
            ones_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_sum[CNT_W-1:0];
            ones_cnt_d = ones_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt_q <= '0;
            ones_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            ones_cnt_q <= ones_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
    assign ones_cnt = ones_cnt_q;
`else
    assign beat_cnt = '0;
    assign ones_cnt = '0;
`endif

endmodule
